// File: rtl/collision_ctrl.sv
// Game-state controller: button debounce, per-frame dino/obstacle collision verdict, IDLE/RUN/DEAD FSM.
// Optional macro HIT_FILTER_EN replaces the single-pixel hit flag with a saturating overlap counter.
module collision_ctrl #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int DEAD_FRAMES     = 30,
  parameter int MIN_HIT_PIXELS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       dino_px,
  input  logic       obstacle_px,
  input  logic       btn,
  output logic       collision,
  output logic       running,
  output logic       restart,
  output logic       frame_tick
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DEAD_W = $clog2(DEAD_FRAMES + 1);

  // The overlap threshold must be reachable by the 8-bit saturating counter.
  if (MIN_HIT_PIXELS < 1 || MIN_HIT_PIXELS > 255) begin : g_bad_min_hit
    $error("collision_ctrl: MIN_HIT_PIXELS out of range 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD
  } state_t;

  state_t state, state_next;

  logic            btn_meta, btn_sync, btn_db, press;
  logic [DB_W-1:0] db_cnt;
  logic [DEAD_W-1:0] dead_cnt;
  logic            visible, frame_end, overlap, hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn;
      btn_sync <= btn_meta;
    end
  end

  // Counter runs only while the synchronized level differs from the debounced one,
  // so any return to the old level restarts the stability window.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_sync == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_cnt <= '0;
        btn_db <= btn_sync;
        press  <= btn_sync;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  always_comb begin
    visible   = (pix_x < 10'(H_ACTIVE)) && (pix_y < 10'(V_ACTIVE));
    frame_end = (pix_x == 10'(H_ACTIVE - 1)) && (pix_y == 10'(V_ACTIVE - 1));
    overlap   = dino_px && obstacle_px && visible;
  end

`ifdef HIT_FILTER_EN
  logic [7:0] hit_cnt;
  logic [8:0] hit_sum;

  always_comb begin
    hit_sum = {1'b0, hit_cnt} + 9'(overlap);
    hit     = hit_sum >= 9'(MIN_HIT_PIXELS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt <= '0;
    end else if (frame_end || state != ST_RUN) begin
      hit_cnt <= '0;
    end else if (overlap && hit_cnt != '1) begin
      hit_cnt <= hit_cnt + 8'd1;
    end
  end
`else
  logic hit_flag;

  always_comb begin
    hit = hit_flag || overlap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_flag <= 1'b0;
    end else if (frame_end || state != ST_RUN) begin
      hit_flag <= 1'b0;
    end else if (overlap) begin
      hit_flag <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (press) state_next = ST_RUN;
      ST_RUN:  if (frame_end && hit) state_next = ST_DEAD;
      ST_DEAD: if (press && dead_cnt >= DEAD_W'(DEAD_FRAMES)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from state_next so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      collision  <= 1'b1;
      running    <= 1'b0;
      restart    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_next;
      collision  <= state_next != ST_RUN;
      running    <= state_next == ST_RUN;
      restart    <= (state == ST_IDLE) && press;
      frame_tick <= frame_end;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dead_cnt <= '0;
    end else if (state != ST_DEAD) begin
      dead_cnt <= '0;
    end else if (frame_end && dead_cnt < DEAD_W'(DEAD_FRAMES)) begin
      dead_cnt <= dead_cnt + DEAD_W'(1);
    end
  end

endmodule

// File: doc/collision_ctrl.md
# collision_ctrl

Game-state controller that sits directly upstream of the score block. It samples the per-pixel dino and obstacle sprite hits while the frame is scanned, and decides once per frame whether a collision occurred. It runs the IDLE/RUN/DEAD game state machine and drives the `collision` level that freezes the score counter. It also debounces the player button used to start and restart a run.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `DEBOUNCE_CYCLES`, 250000: stable cycles required on the button, 10 ms at 25 MHz.
- `DEAD_FRAMES`, 30: minimum frames spent in DEAD before a restart press is accepted.
- `MIN_HIT_PIXELS`, 4: overlap pixels per frame needed to declare a hit. Used only with `HIT_FILTER_EN`.
- `clk` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `pix_x` in 10: current pixel column from VGA sync.
- `pix_y` in 10: current pixel row from VGA sync.
- `dino_px` in 1: dino sprite covers the current pixel.
- `obstacle_px` in 1: obstacle sprite covers the current pixel.
- `btn` in 1: raw, asynchronous player button.
- `collision` out 1: high whenever state ≠ RUN; feeds score.
- `running` out 1: high in RUN.
- `restart` out 1: one-cycle pulse on the IDLE→RUN transition; clears obstacle and score logic.
- `frame_tick` out 1: one-cycle pulse at end of the visible frame.

## Operation
- **Button path**
  - `btn` passes through a 2-flop synchronizer.
  - The debounce counter resets on any change of the synchronized level. The debounced level updates after `DEBOUNCE_CYCLES` consecutive stable cycles.
  - `press` is the rising edge of the debounced level and lasts one cycle.
- **Visible area and frame end**
  - Visible area: `pix_x < H_ACTIVE` and `pix_y < V_ACTIVE`.
  - `frame_end`: `pix_x == H_ACTIVE-1` and `pix_y == V_ACTIVE-1`.
- **Overlap accumulation**
  - Accumulation happens only in RUN and only in the visible area.
  - Each cycle with `dino_px && obstacle_px` sets `hit_flag`.
  - At `frame_end`, the verdict is `hit = hit_flag OR overlap on this cycle`. Then `hit_flag` clears.
- **State machine** (reset state IDLE)
  - IDLE → RUN on `press`. `restart` pulses on the same edge.
  - RUN → DEAD at `frame_end` when `hit` is true.
  - RUN ignores `press`; jumping is handled by the dino block.
  - DEAD → IDLE on `press` when `dead_cnt >= DEAD_FRAMES`.
  - `dead_cnt` clears on entry to DEAD, increments on each `frame_end`, and saturates at `DEAD_FRAMES`.
- A `press` in DEAD before `dead_cnt` reaches `DEAD_FRAMES` is dropped, not queued.
- The outputs `collision`, `running` and `frame_tick` are registered.

## Timing
- **Reset values:** state=IDLE, `collision`=1, `running`=0, `restart`=0, `frame_tick`=0, `hit_flag`=0, `dead_cnt`=0, synchronizer/debounced level=0, debounce counter=0.
- **Reset mid-run:** returns to IDLE on the next edge and discards any accumulated hit.
- **`frame_tick`** is high for the one cycle after the `frame_end` pixel edge.
- **Hit latency:** on the `frame_end` cycle of a hit frame, `collision` rises at the next edge, the same edge as `frame_tick`.
  - An overlap on the `frame_end` pixel itself counts toward that frame.
- **Button latency:** the registered `press` follows a clean `btn` edge by 2 + `DEBOUNCE_CYCLES` cycles.
  - `restart`, `running` and the fall of `collision` occur on the edge after `press`.
- **Simultaneous events:** a hit verdict and a `press` in the same cycle while in RUN produce DEAD; the press is ignored.

## Configuration
- **`HIT_FILTER_EN` defined:**
  - `hit_flag` is replaced by an 8-bit overlap-pixel counter, saturating at 255 and cleared at `frame_end`.
  - `hit` = (count + current overlap) ≥ `MIN_HIT_PIXELS`.
  - This rejects single-pixel sprite-edge grazes.
- **Undefined:** a single overlapping pixel in a frame is a hit; no counter is synthesized.

## Test plan
- **Reset:** assert `rst` for 2 cycles → `collision`=1, `running`=0, `restart`=0. Held until a press.
- **Debounce:** bounce `btn` 5 times, each shorter than `DEBOUNCE_CYCLES` (use 16 in sim), then hold high → exactly one `restart` pulse. Then `running`=1 and `collision`=0.
- **Hit detection:** in RUN, drive one overlap pixel at (100,200), filter off → `collision` rises on the edge after the (639,479) pixel; `frame_tick` is coincident.
- **Filter (`HIT_FILTER_EN`, `MIN_HIT_PIXELS`=4):**
  - 3 overlap pixels in frame 1 → stays RUN.
  - 4 overlap pixels in frame 2 → DEAD at end of frame 2.
- **Dead lockout (`DEAD_FRAMES`=3):**
  - Press after 1 frame in DEAD → ignored.
  - Press after 3 frames → IDLE.
  - Second press → RUN with `restart` pulse.
- **Boundary cases:**
  - Overlap only at pixel (639,479) → hit in that frame.
  - Overlap at `pix_x`=700 (blanking) → no hit.
  - `rst` during RUN with `hit_flag` set → IDLE, no DEAD.
